tcm_boot_loader: RTL and testbench
==================================

# tcm_boot_loader

Synthesizable boot loader that replaces the simulation-only TCM preload. After reset it fills the DTCM with a constant word, then packs an incoming byte stream into words and writes them sequentially into the ITCM. Optionally it zero-pads the rest of the ITCM. It then releases the core from reset with a configured reset vector. It sits between the external boot byte source, the ITCM/DTCM write ports of the SRAM wrapper, and the core's `rst_n`/`pc_rtvec` inputs.

## Interface
- `DW`, 32: TCM word width. Must be a multiple of 8. `BPW = DW/8`.
- `ITCM_AW`, 12: ITCM word-address width.
- `ITCM_DEPTH`, 3500: number of ITCM words. Must be ≤ 2^ITCM_AW.
- `DTCM_AW`, 12: DTCM word-address width.
- `DTCM_DEPTH`, 3500: number of DTCM words to fill.
- `DTCM_FILL`, 'h1: value written to every DTCM word.
- `BYTE_SWAP`, 0: byte order.
  - 0: the first byte of each word goes to bits [7:0] (little-endian).
  - 1: the first byte goes to bits [DW-1:DW-8].
- `RESET_PC`, 'h0000_0080: value driven on `pc_rtvec`, width `PC_SIZE`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: boot byte valid.
- `s_ready` out 1: boot byte accepted when `s_valid && s_ready`.
- `s_data` in 8: boot byte.
- `s_last` in 1: marks the final byte of the image.
- `itcm_cs`, `itcm_we` out 1: ITCM write strobe.
- `itcm_addr` out ITCM_AW: ITCM word address.
- `itcm_wdata` out DW: ITCM write data.
- `dtcm_cs`, `dtcm_we` out 1: DTCM write strobe.
- `dtcm_addr` out DTCM_AW: DTCM word address.
- `dtcm_wdata` out DW: DTCM write data.
- `core_rst_n` out 1: core reset, low until load completes.
- `pc_rtvec` out PC_SIZE: core reset vector, constant `RESET_PC`.
- `done` out 1: load finished (sticky).
- `err` out 1: overflow (sticky).

## Operation
- The state machine has four states: FILL → LOAD → PAD → DONE. DONE is terminal until `rst_n` is asserted.
- **FILL**: writes `DTCM_FILL` to addresses 0..DTCM_DEPTH-1, one word per cycle.
  - `s_ready` is 0 throughout.
  - Moves to LOAD after address DTCM_DEPTH-1 is written.
- **LOAD**: `s_ready` is 1.
  - Each accepted byte is placed in byte lane `k` (k = 0..BPW-1) according to `BYTE_SWAP`.
  - When lane BPW-1 is accepted, the assembled word is written to ITCM at the current word address, and the address increments.
  - When `s_last` is accepted with k < BPW-1, the unfilled lanes are zero and the partial word is written.
  - The state advances after the `s_last` word is written.
- **Overflow**: bytes that arrive after ITCM_DEPTH words have been written are accepted and dropped.
  - `s_ready` stays 1 (the stream drains).
  - `err` sets and stays set.
  - The address does not wrap.
- **PAD**: behaviour depends on the configuration macro (see Configuration). Without the macro, PAD is skipped.
- **DONE**: `core_rst_n` = 1, `done` = 1, `s_ready` = 0, and all TCM strobes are 0.
- ITCM and DTCM writes never occur in the same cycle.

## Timing
- Reset values:
  - State FILL.
  - All strobes 0; all addresses and wdata 0.
  - `s_ready` 0, `core_rst_n` 0, `done` 0, `err` 0.
  - `pc_rtvec` = RESET_PC.
- All outputs are registered.
- FILL lasts exactly DTCM_DEPTH cycles, starting on the first clock edge after `rst_n` deasserts.
- An ITCM write is asserted for one cycle, on the cycle after the word's final byte handshake. Back-to-back bytes are sustained with no stall, at a peak of one word every BPW cycles.
- `core_rst_n` and `done` rise on the cycle after the last ITCM write, whether that is the final LOAD word or the last PAD word.
- `rst_n` asserted mid-load aborts immediately: partial-word state is discarded and the block restarts at FILL.

## Configuration
- `TCM_BOOT_LOADER_PAD_EN` defined: PAD writes zero to ITCM addresses from the next unwritten address through ITCM_DEPTH-1, one per cycle. PAD takes zero cycles if the ITCM is already full.
- `TCM_BOOT_LOADER_PAD_EN` not defined: LOAD goes directly to DONE, and unwritten ITCM words keep their previous contents.

## Structure
- Package `tcm_boot_loader_pkg` holds:
  - the state typedef (FILL/LOAD/PAD/DONE);
  - the `PC_SIZE` import from the shared defines;
  - the `BPW` helper function.
- Sub-module `tcm_word_packer` handles byte-lane placement, the lane counter, partial-word zero-fill on `s_last`, and the word-valid pulse.

## Test plan
- Reset release, DTCM_DEPTH=8, DTCM_FILL='h1 → `dtcm_we` high for exactly 8 cycles, addresses 0..7, data 'h1; `s_ready` is 0 during this period.
- BYTE_SWAP=0, stream 13 05 00 00 (last) → ITCM[0]='h0000_0513; `core_rst_n` rises on the next cycle.
- BYTE_SWAP=1, same stream → ITCM[0]='h1305_0000.
- 6 bytes AA BB CC DD 11 22 (last on 22), BYTE_SWAP=0 → ITCM[0]='hDDCC_BBAA, ITCM[1]='h0000_2211.
- ITCM_DEPTH=2, 12-byte stream → 2 words written; `err`=1; all 12 bytes handshaken; `done`=1.
- PAD_EN defined, ITCM_DEPTH=4, one-word image → ITCM[1..3] written with 0 on consecutive cycles, then `done`. Separately, `rst_n` pulsed mid-LOAD → block restarts in FILL with `core_rst_n` = 0.

Source files
------------

// File: rtl/tcm_boot_loader_pkg.sv
// Shared types and helpers for the TCM boot loader: FSM state encoding,
// core reset-vector width and the bytes-per-word helper.
package tcm_boot_loader_pkg;

    // Matches the core's reset-vector width from the shared core defines.
    localparam int PC_SIZE = 32;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int bpw(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/tcm_word_packer.sv
// Packs an accepted byte stream into DW-bit words; emits a combinational
// word-valid pulse on the final lane or on the last byte (zero-filled tail).
module tcm_word_packer
    import tcm_boot_loader_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BYTE_SWAP = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          byte_vld,
    input  logic [7:0]    byte_data,
    input  logic          byte_last,
    output logic          word_vld,
    output logic [DW-1:0] word_data
);

    localparam int BPW = bpw(DW);
    localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [LW-1:0] lane_q, lane_d;
    logic [DW-1:0] lanes_q, lanes_d;
    logic          last_lane_s;

    // Merge the incoming byte into its lane and decide when a word is complete
    always_comb begin
        word_data = lanes_q;
        for (int k = 0; k < BPW; k++) begin
            word_data[((BYTE_SWAP != 0) ? (BPW - 1 - k) : k) * 8 +: 8] =
                (lane_q == LW'(k)) ? byte_data
                                   : lanes_q[((BYTE_SWAP != 0) ? (BPW - 1 - k) : k) * 8 +: 8];
        end
        last_lane_s = (lane_q == LW'(BPW - 1));
        word_vld    = byte_vld && (last_lane_s || byte_last);
        lane_d      = lane_q;
        lanes_d     = lanes_q;
        // Clearing after each word is what leaves unfilled lanes of a short tail at zero.
        if (word_vld) begin
            lane_d  = {LW{1'b0}};
            lanes_d = {DW{1'b0}};
        end else if (byte_vld) begin
            lane_d  = lane_q + LW'(1);
            lanes_d = word_data;
        end else begin
            lane_d  = lane_q;
            lanes_d = lanes_q;
        end
    end

    // Lane counter and partially assembled word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= {LW{1'b0}};
            lanes_q <= {DW{1'b0}};
        end else begin
            lane_q  <= lane_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/tcm_boot_loader.sv
// Boot loader: fills DTCM with a constant, streams a byte image into ITCM,
// then releases the core. Optional ITCM zero-padding: TCM_BOOT_LOADER_PAD_EN.
module tcm_boot_loader
    import tcm_boot_loader_pkg::*;
#(
    parameter int                  DW         = 32,
    parameter int                  ITCM_AW    = 12,
    parameter int                  ITCM_DEPTH = 3500,
    parameter int                  DTCM_AW    = 12,
    parameter int                  DTCM_DEPTH = 3500,
    parameter logic [DW-1:0]       DTCM_FILL  = {{(DW-1){1'b0}}, 1'b1},
    parameter int                  BYTE_SWAP  = 0,
    parameter logic [PC_SIZE-1:0]  RESET_PC   = 32'h0000_0080
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 itcm_cs,
    output logic                 itcm_we,
    output logic [ITCM_AW-1:0]   itcm_addr,
    output logic [DW-1:0]        itcm_wdata,
    output logic                 dtcm_cs,
    output logic                 dtcm_we,
    output logic [DTCM_AW-1:0]   dtcm_addr,
    output logic [DW-1:0]        dtcm_wdata,
    output logic                 core_rst_n,
    output logic [PC_SIZE-1:0]   pc_rtvec,
    output logic                 done,
    output logic                 err
);

    // One extra bit so the word count can reach ITCM_DEPTH == 2^ITCM_AW without wrapping.
    localparam int                 CW        = ITCM_AW + 1;
    localparam logic [CW-1:0]      ITCM_END  = CW'(ITCM_DEPTH);
    localparam logic [DTCM_AW-1:0] FILL_LAST = DTCM_AW'(DTCM_DEPTH - 1);

    state_e               state_q, state_d;
    logic [DTCM_AW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic                 itcm_we_q, itcm_we_d;
    logic [ITCM_AW-1:0]   itcm_addr_q, itcm_addr_d;
    logic [DW-1:0]        itcm_wdata_q, itcm_wdata_d;
    logic                 dtcm_we_q, dtcm_we_d;
    logic [DTCM_AW-1:0]   dtcm_addr_q, dtcm_addr_d;
    logic [DW-1:0]        dtcm_wdata_q, dtcm_wdata_d;
    logic                 s_ready_q, s_ready_d;
    logic                 core_rst_n_q, core_rst_n_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 hs_s;
    logic                 full_s;
    logic                 word_vld_s;
    logic [DW-1:0]        word_s;

    assign hs_s   = s_valid && s_ready_q;
    assign full_s = (wcnt_q == ITCM_END);

    tcm_word_packer #(
        .DW        (DW),
        .BYTE_SWAP (BYTE_SWAP)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_vld  (hs_s),
        .byte_data (s_data),
        .byte_last (s_last),
        .word_vld  (word_vld_s),
        .word_data (word_s)
    );

    // Next-state and next-output logic for FILL -> LOAD -> (PAD) -> DONE
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        wcnt_d       = wcnt_q;
        itcm_we_d    = 1'b0;
        itcm_addr_d  = itcm_addr_q;
        itcm_wdata_d = itcm_wdata_q;
        dtcm_we_d    = 1'b0;
        dtcm_addr_d  = dtcm_addr_q;
        dtcm_wdata_d = dtcm_wdata_q;
        err_d        = err_q;
        case (state_q)
            ST_FILL: begin
                dtcm_we_d    = 1'b1;
                dtcm_addr_d  = fill_cnt_q;
                dtcm_wdata_d = DTCM_FILL;
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    fill_cnt_d = fill_cnt_q + DTCM_AW'(1);
                end
            end
            ST_LOAD: begin
                // Once ITCM is full the stream keeps draining but every byte is dropped.
                if (hs_s && full_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (word_vld_s && !full_s) begin
                    itcm_we_d    = 1'b1;
                    itcm_addr_d  = wcnt_q[ITCM_AW-1:0];
                    itcm_wdata_d = word_s;
                    wcnt_d       = wcnt_q + CW'(1);
                end else begin
                    wcnt_d = wcnt_q;
                end
                if (hs_s && s_last) begin
`ifdef TCM_BOOT_LOADER_PAD_EN
                    state_d = (wcnt_d == ITCM_END) ? ST_DONE : ST_PAD;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_PAD: begin
`ifdef TCM_BOOT_LOADER_PAD_EN
                if (full_s) begin
                    state_d = ST_DONE;
                end else begin
                    itcm_we_d    = 1'b1;
                    itcm_addr_d  = wcnt_q[ITCM_AW-1:0];
                    itcm_wdata_d = {DW{1'b0}};
                    wcnt_d       = wcnt_q + CW'(1);
                    state_d      = (wcnt_d == ITCM_END) ? ST_DONE : ST_PAD;
                end
`else
                state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        // Ready follows LOAD one cycle late, so it never overlaps the last DTCM write.
        s_ready_d    = (state_q == ST_LOAD) && (state_d == ST_LOAD);
        core_rst_n_d = (state_q == ST_DONE);
        done_d       = (state_q == ST_DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            fill_cnt_q   <= {DTCM_AW{1'b0}};
            wcnt_q       <= {CW{1'b0}};
            itcm_we_q    <= 1'b0;
            itcm_addr_q  <= {ITCM_AW{1'b0}};
            itcm_wdata_q <= {DW{1'b0}};
            dtcm_we_q    <= 1'b0;
            dtcm_addr_q  <= {DTCM_AW{1'b0}};
            dtcm_wdata_q <= {DW{1'b0}};
            s_ready_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            wcnt_q       <= wcnt_d;
            itcm_we_q    <= itcm_we_d;
            itcm_addr_q  <= itcm_addr_d;
            itcm_wdata_q <= itcm_wdata_d;
            dtcm_we_q    <= dtcm_we_d;
            dtcm_addr_q  <= dtcm_addr_d;
            dtcm_wdata_q <= dtcm_wdata_d;
            s_ready_q    <= s_ready_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign itcm_cs    = itcm_we_q;
    assign itcm_we    = itcm_we_q;
    assign itcm_addr  = itcm_addr_q;
    assign itcm_wdata = itcm_wdata_q;
    assign dtcm_cs    = dtcm_we_q;
    assign dtcm_we    = dtcm_we_q;
    assign dtcm_addr  = dtcm_addr_q;
    assign dtcm_wdata = dtcm_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pc_rtvec   = RESET_PC;

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Directed bench for tcm_boot_loader: two instances (little-endian depth 4,
// big-endian depth 2) covering fill, packing, overflow, padding and abort.
module tb_tcm_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic v0, l0, v1, l1;
    logic [7:0] d0, d1;

    logic r0, ic0, iw0, dc0, dw0, crst0, done0, err0;
    logic [3:0] ia0, da0;
    logic [31:0] id0, dd0, pc0;
    logic r1, ic1, iw1, dc1, dw1, crst1, done1, err1;
    logic [3:0] ia1, da1;
    logic [31:0] id1, dd1, pc1;

    tcm_boot_loader #(
        .DW(32), .ITCM_AW(4), .ITCM_DEPTH(4), .DTCM_AW(4), .DTCM_DEPTH(8),
        .DTCM_FILL(32'h1), .BYTE_SWAP(0), .RESET_PC(32'h0000_0080)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .s_valid(v0), .s_ready(r0), .s_data(d0), .s_last(l0),
        .itcm_cs(ic0), .itcm_we(iw0), .itcm_addr(ia0), .itcm_wdata(id0),
        .dtcm_cs(dc0), .dtcm_we(dw0), .dtcm_addr(da0), .dtcm_wdata(dd0),
        .core_rst_n(crst0), .pc_rtvec(pc0), .done(done0), .err(err0)
    );

    tcm_boot_loader #(
        .DW(32), .ITCM_AW(4), .ITCM_DEPTH(2), .DTCM_AW(4), .DTCM_DEPTH(8),
        .DTCM_FILL(32'h1), .BYTE_SWAP(1), .RESET_PC(32'h0000_0080)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .s_valid(v1), .s_ready(r1), .s_data(d1), .s_last(l1),
        .itcm_cs(ic1), .itcm_we(iw1), .itcm_addr(ia1), .itcm_wdata(id1),
        .dtcm_cs(dc1), .dtcm_we(dw1), .dtcm_addr(da1), .dtcm_wdata(dd1),
        .core_rst_n(crst1), .pc_rtvec(pc1), .done(done1), .err(err1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    int wr0, wr1, first_w0, last_w0, last_w1, rise0, rise1, fill0, hs1cnt, hs_cyc0;
    logic crst0_p, crst1_p;

    // Write monitor: mirrors ITCM contents and checks the DTCM fill sequence
    always @(negedge clk) begin
        if (rst_n) begin
            if (iw0) begin
                mem0[ia0] = id0;
                if (wr0 == 0) first_w0 = cyc;
                last_w0 = cyc;
                wr0++;
            end
            if (iw1) begin
                mem1[ia1] = id1;
                last_w1 = cyc;
                wr1++;
            end
            if (dw0) begin
                check_eq("fill_addr", {28'd0, da0}, fill0);
                check_eq("fill_data", dd0, 32'h1);
                check_eq("fill_cs", {31'd0, dc0}, 32'h1);
                check_eq("fill_rdy_low", {31'd0, r0}, 32'h0);
                fill0++;
            end
            if (crst0 && !crst0_p) rise0 = cyc;
            if (crst1 && !crst1_p) rise1 = cyc;
            crst0_p = crst0;
            crst1_p = crst1;
        end
    end

    task automatic send(input int which, input logic [7:0] b, input logic last);
        int n = 0;
        logic rdy = 1'b0;
        if (which == 0) begin v0 = 1'b1; d0 = b; l0 = last; end
        else            begin v1 = 1'b1; d1 = b; l1 = last; end
        forever begin
            @(negedge clk);
            rdy = (which == 0) ? r0 : r1;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 100) begin
                check_eq("hs_timeout", {31'd0, rdy}, 32'h1);
                break;
            end
        end
        #1;
        if (which == 0) begin v0 = 1'b0; l0 = 1'b0; if (rdy) hs_cyc0 = cyc; end
        else            begin v1 = 1'b0; l1 = 1'b0; if (rdy) hs1cnt++; end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        #1;
        check_eq("rst_itcm_we", {31'd0, iw0}, 32'h0);
        check_eq("rst_itcm_addr", {28'd0, ia0}, 32'h0);
        check_eq("rst_itcm_wdata", id0, 32'h0);
        check_eq("rst_dtcm_we", {31'd0, dw0}, 32'h0);
        check_eq("rst_dtcm_wdata", dd0, 32'h0);
        check_eq("rst_s_ready", {31'd0, r0}, 32'h0);
        check_eq("rst_core_rst_n", {31'd0, crst0}, 32'h0);
        check_eq("rst_done_err", {30'd0, done0, err0}, 32'h0);
        check_eq("rst_pc_rtvec", pc0, 32'h0000_0080);
        wr0 = 0; wr1 = 0; fill0 = 0; hs1cnt = 0;
        first_w0 = -1; last_w0 = -1; last_w1 = -1; rise0 = -1; rise1 = -1; hs_cyc0 = -2;
        crst0_p = 1'b0; crst1_p = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 32'hDEAD_BEEF;
            mem1[i] = 32'hDEAD_BEEF;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("fill_cycles", fill0, 32'd8);
        check_eq("ready_after_fill", {30'd0, r0, r1}, 32'h3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; d0 = 8'h00; d1 = 8'h00;

        // Run 1: single-word image on both instances
        do_reset();
        send(0, 8'h13, 1'b0); send(0, 8'h05, 1'b0); send(0, 8'h00, 1'b0); send(0, 8'h00, 1'b1);
        send(1, 8'h13, 1'b0); send(1, 8'h05, 1'b0); send(1, 8'h00, 1'b0); send(1, 8'h00, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_eq("le_word0", mem0[0], 32'h0000_0513);
        check_eq("le_write_latency", first_w0, hs_cyc0);
        check_eq("le_rise_after_last_write", rise0, last_w0 + 1);
        check_eq("le_done_sticky", {30'd0, done0, crst0}, 32'h3);
        check_eq("le_rdy_done_err", {30'd0, r0, err0}, 32'h0);
        check_eq("be_word0", mem1[0], 32'h1305_0000);
        check_eq("be_rise_after_last_write", rise1, last_w1 + 1);
`ifdef TCM_BOOT_LOADER_PAD_EN
        check_eq("pad_writes", wr0, 32'd4);
        check_eq("pad_consecutive", last_w0 - first_w0, 32'd3);
        check_eq("pad_word1", mem0[1], 32'h0);
        check_eq("pad_word2", mem0[2], 32'h0);
        check_eq("pad_word3", mem0[3], 32'h0);
`else
        check_eq("nopad_writes", wr0, 32'd1);
        check_eq("nopad_word1_kept", mem0[1], 32'hDEAD_BEEF);
`endif

        // Run 2: two-word image with partial tail; overflow on the depth-2 instance
        do_reset();
        send(0, 8'hAA, 1'b0); send(0, 8'hBB, 1'b0); send(0, 8'hCC, 1'b0);
        send(0, 8'hDD, 1'b0); send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b1);
        for (int i = 1; i <= 12; i++) send(1, 8'(i), (i == 12) ? 1'b1 : 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check_eq("le_pair_word0", mem0[0], 32'hDDCC_BBAA);
        check_eq("le_pair_word1", mem0[1], 32'h0000_2211);
        check_eq("le_pair_no_err", {31'd0, err0}, 32'h0);
        check_eq("ovf_handshakes", hs1cnt, 32'd12);
        check_eq("ovf_writes", wr1, 32'd2);
        check_eq("ovf_word0", mem1[0], 32'h0102_0304);
        check_eq("ovf_word1", mem1[1], 32'h0506_0708);
        check_eq("ovf_err_done", {30'd0, err1, done1}, 32'h3);
        check_eq("ovf_no_wrap", mem1[2], 32'hDEAD_BEEF);

        // Run 3: reset pulsed mid-word, then a clean image
        do_reset();
        send(0, 8'h77, 1'b0); send(0, 8'h66, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_core_rst_n", {31'd0, crst0}, 32'h0);
        check_eq("abort_strobes", {29'd0, r0, iw0, dw0}, 32'h0);
        do_reset();
        send(0, 8'h13, 1'b0); send(0, 8'h05, 1'b0); send(0, 8'h00, 1'b0); send(0, 8'h00, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_eq("abort_fresh_word0", mem0[0], 32'h0000_0513);
        check_eq("abort_done", {31'd0, done0}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
